// File: rtl/arm_mem_dualport_hs_if.sv
// Two-port request/response bundle for arm_mem_dualport_hs.
// Port p occupies bit p of the 1-bit fields and slice [W*p +: W] of the wider ones.
interface arm_mem_dualport_hs_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [7:0]  req_be;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_excpt;
    logic [3:0]  resp_cause;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_excpt, resp_cause
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_excpt, resp_cause
    );
endinterface

// File: rtl/arm_mem_dualport_hs.sv
// Two-port byte-addressed data/text memory with valid/ready handshakes, wait states and cause codes.
// Define ARM_MEM_STRICT_ALIGN_EN to fault unaligned accesses with cause 2.
module arm_mem_dualport_hs #(
    parameter logic [31:0] DATA_START    = 32'h1000_0000,
    parameter logic [31:0] DATA_SIZE     = 32'h0000_0100,
    parameter logic [31:0] TEXT_START    = 32'h0000_0000,
    parameter logic [31:0] TEXT_SIZE     = 32'h0000_0100,
    parameter int unsigned WAIT_STATES   = 0,
    parameter bit          TEXT_WRITABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arm_mem_dualport_hs_if.slave  bus
);
    localparam int unsigned DAW = (DATA_SIZE > 32'd1) ? $clog2(DATA_SIZE) : 1;
    localparam int unsigned TAW = (TEXT_SIZE > 32'd1) ? $clog2(TEXT_SIZE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [32:0] DATA_END = {1'b0, DATA_START} + {1'b0, DATA_SIZE};
    localparam logic [32:0] TEXT_END = {1'b0, TEXT_START} + {1'b0, TEXT_SIZE};

    logic [7:0] dmem [0:DATA_SIZE-1];
    logic [7:0] tmem [0:TEXT_SIZE-1];

    logic [1:0]     wr_data;
    logic [1:0]     wr_text;
    logic [DAW-1:0] doff_a [2];
    logic [TAW-1:0] toff_a [2];

    logic [1:0]  rdy_v;
    logic [1:0]  vld_v;
    logic [63:0] rdata_v;
    logic [1:0]  excpt_v;
    logic [3:0]  cause_v;

    for (genvar gp = 0; gp < 2; gp++) begin : g_port
        logic [31:0]    addr;
        logic           we;
        logic [32:0]    addr_last;
        logic           in_data;
        logic           in_text;
        logic           misal;
        logic [1:0]     cause;
        logic           excpt;
        logic [DAW-1:0] doff;
        logic [TAW-1:0] toff;
        logic [31:0]    rword;
        logic           accept;

        logic [1:0]     state;
        logic [3:0]     cnt;
        logic           rdy;
        logic [31:0]    rdata_q;
        logic           excpt_q;
        logic [1:0]     cause_q;

        assign addr      = bus.req_addr[32*gp +: 32];
        assign we        = bus.req_we[gp];
        assign addr_last = {1'b0, addr} + 33'd3;
        assign in_data   = (addr >= DATA_START) && (addr_last < DATA_END);
        assign in_text   = (addr >= TEXT_START) && (addr_last < TEXT_END);

`ifdef ARM_MEM_STRICT_ALIGN_EN
        assign misal = |addr[1:0];
`else
        assign misal = 1'b0;
`endif

        // Data region wins if the two regions were ever configured to overlap.
        always_comb begin
            cause = 2'd0;
            if (!(in_data || in_text)) begin
                cause = 2'd1;
            end else if (misal) begin
                cause = 2'd2;
            end else if (we && !in_data && !TEXT_WRITABLE) begin
                cause = 2'd3;
            end
        end

        assign excpt = |cause;
        assign doff  = DAW'(addr - DATA_START);
        assign toff  = TAW'(addr - TEXT_START);

        always_comb begin
            rword = '0;
            for (int unsigned k = 0; k < 4; k++) begin
                rword[31-8*k -: 8] = in_data ? dmem[doff + DAW'(k)] : tmem[toff + TAW'(k)];
            end
        end

        assign accept      = bus.req_valid[gp] & rdy;
        assign wr_data[gp] = accept & we & ~excpt & in_data;
        assign wr_text[gp] = accept & we & ~excpt & ~in_data & in_text;
        assign doff_a[gp]  = doff;
        assign toff_a[gp]  = toff;

        // WAIT is always visited (counter starts at WAIT_STATES) so the response
        // lands WAIT_STATES+1 edges after acceptance, including the zero-wait case.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= S_IDLE;
                cnt     <= '0;
                rdy     <= 1'b0;
                rdata_q <= '0;
                excpt_q <= 1'b0;
                cause_q <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        rdy <= 1'b1;
                        if (accept) begin
                            state   <= S_WAIT;
                            cnt     <= 4'(WAIT_STATES);
                            rdy     <= 1'b0;
                            rdata_q <= (excpt || we) ? '0 : rword;
                            excpt_q <= excpt;
                            cause_q <= cause;
                        end
                    end
                    S_WAIT: begin
                        if (cnt == 4'd0) begin
                            state <= S_RESP;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_RESP: begin
                        if (bus.resp_ready[gp]) begin
                            state <= S_IDLE;
                            rdy   <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        rdy   <= 1'b0;
                    end
                endcase
            end
        end

        assign rdy_v[gp]            = rdy;
        assign vld_v[gp]            = (state == S_RESP);
        assign rdata_v[32*gp +: 32] = rdata_q;
        assign excpt_v[gp]          = excpt_q;
        assign cause_v[2*gp +: 2]   = cause_q;
    end

    // Port 1 is applied last so it wins any byte both ports write on the same edge.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (wr_data[p] && bus.req_be[4*p + 3 - k]) begin
                    dmem[doff_a[p] + DAW'(k)] <= bus.req_wdata[32*p + 31 - 8*k -: 8];
                end
                if (wr_text[p] && bus.req_be[4*p + 3 - k]) begin
                    tmem[toff_a[p] + TAW'(k)] <= bus.req_wdata[32*p + 31 - 8*k -: 8];
                end
            end
        end
    end

    assign bus.req_ready  = rdy_v;
    assign bus.resp_valid = vld_v;
    assign bus.resp_rdata = rdata_v;
    assign bus.resp_excpt = excpt_v;
    assign bus.resp_cause = cause_v;
endmodule

// File: tb/tb_arm_mem_dualport_hs.sv
// Directed bench for arm_mem_dualport_hs: a zero-wait text-writable instance and a
// three-wait text-protected instance share clock and reset.
module tb_arm_mem_dualport_hs;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    arm_mem_dualport_hs_if ia();
    arm_mem_dualport_hs_if ib();

    arm_mem_dualport_hs #(.WAIT_STATES(0), .TEXT_WRITABLE(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia)
    );

    arm_mem_dualport_hs #(.WAIT_STATES(3), .TEXT_WRITABLE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit sel, input int p, input logic v, input logic we,
                       input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        if (sel) begin
            ib.req_valid[p] = v; ib.req_we[p] = we; ib.req_be[4*p +: 4] = be;
            ib.req_addr[32*p +: 32] = addr; ib.req_wdata[32*p +: 32] = wd;
        end else begin
            ia.req_valid[p] = v; ia.req_we[p] = we; ia.req_be[4*p +: 4] = be;
            ia.req_addr[32*p +: 32] = addr; ia.req_wdata[32*p +: 32] = wd;
        end
    endtask

    task automatic rresp(input bit sel, input int p, input logic r);
        if (sel) ib.resp_ready[p] = r;
        else     ia.resp_ready[p] = r;
    endtask

    task automatic sample(input bit sel, input int p, output logic rdy, output logic vld,
                          output logic ex, output logic [1:0] cs, output logic [31:0] rd);
        if (sel) begin
            rdy = ib.req_ready[p]; vld = ib.resp_valid[p]; ex = ib.resp_excpt[p];
            cs = ib.resp_cause[2*p +: 2]; rd = ib.resp_rdata[32*p +: 32];
        end else begin
            rdy = ia.req_ready[p]; vld = ia.resp_valid[p]; ex = ia.resp_excpt[p];
            cs = ia.resp_cause[2*p +: 2]; rd = ia.resp_rdata[32*p +: 32];
        end
    endtask

    // Full single-port transaction; lat = edges from acceptance until resp_valid.
    task automatic txn(input bit sel, input int p, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic ex, output logic [1:0] cs,
                       output int lat);
        logic rdy, vld;
        int t;
        @(posedge clk); #1;
        drv(sel, p, 1'b1, we, be, addr, wd);
        t = 0;
        sample(sel, p, rdy, vld, ex, cs, rd);
        while (!rdy && t < 20) begin
            @(posedge clk); #1; t++;
            sample(sel, p, rdy, vld, ex, cs, rd);
        end
        if (t == 20) chk("req_ready_timeout", rdy, 1'b1);
        @(posedge clk); #1;
        drv(sel, p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        lat = 0;
        sample(sel, p, rdy, vld, ex, cs, rd);
        while (!vld && lat < 20) begin
            @(posedge clk); #1; lat++;
            sample(sel, p, rdy, vld, ex, cs, rd);
        end
        if (lat == 20) chk("resp_valid_timeout", vld, 1'b1);
        rresp(sel, p, 1'b1);
        @(posedge clk); #1;
        rresp(sel, p, 1'b0);
    endtask

    // Both ports of instance A issue on the same acceptance edge.
    task automatic dual_a(input logic we0, input logic [3:0] be0, input logic [31:0] a0, input logic [31:0] d0,
                          input logic we1, input logic [3:0] be1, input logic [31:0] a1, input logic [31:0] d1,
                          output logic [31:0] rd0, output logic [31:0] rd1);
        int t;
        @(posedge clk); #1;
        drv(0, 0, 1'b1, we0, be0, a0, d0);
        drv(0, 1, 1'b1, we1, be1, a1, d1);
        t = 0;
        while (ia.req_ready != 2'b11 && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (t == 20) chk("dual_ready_timeout", ia.req_ready, 2'b11);
        @(posedge clk); #1;
        drv(0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv(0, 1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        t = 0;
        while (ia.resp_valid != 2'b11 && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (t == 20) chk("dual_valid_timeout", ia.resp_valid, 2'b11);
        rd0 = ia.resp_rdata[31:0];
        rd1 = ia.resp_rdata[63:32];
        ia.resp_ready = 2'b11;
        @(posedge clk); #1;
        ia.resp_ready = 2'b00;
    endtask

    logic [31:0] rd, rd0, rd1, v0;
    logic        ex;
    logic [1:0]  cs;
    int          lat;
    logic        bad;

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        ia.req_valid = '0; ia.req_we = '0; ia.req_be = '0; ia.req_addr = '0;
        ia.req_wdata = '0; ia.resp_ready = '0;
        ib.req_valid = '0; ib.req_we = '0; ib.req_be = '0; ib.req_addr = '0;
        ib.req_wdata = '0; ib.resp_ready = '0;

        #2;
        chk("rst_req_ready_a", ia.req_ready, 2'b00);
        chk("rst_resp_valid_a", ia.resp_valid, 2'b00);
        chk("rst_rdata_a", ia.resp_rdata, 64'h0);
        chk("rst_excpt_cause_a", {ia.resp_excpt, ia.resp_cause}, 6'h0);
        chk("rst_req_ready_b", ib.req_ready, 2'b00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready_a", ia.req_ready, 2'b11);
        chk("post_rst_ready_b", ib.req_ready, 2'b11);

        txn(0, 0, 1'b1, 4'hF, 32'h1000_0010, 32'hDEAD_BEEF, rd, ex, cs, lat);
        chk("wr_excpt", ex, 1'b0);
        chk("wr_latency", lat, 1);
        txn(0, 0, 1'b0, 4'hF, 32'h1000_0010, 32'h0, rd, ex, cs, lat);
        chk("rd_deadbeef", rd, 32'hDEAD_BEEF);
        chk("rd_excpt", ex, 1'b0);
        chk("rd_latency", lat, 1);

        txn(0, 0, 1'b1, 4'b0101, 32'h1000_0010, 32'h1122_3344, rd, ex, cs, lat);
        txn(0, 1, 1'b0, 4'hF, 32'h1000_0010, 32'h0, rd, ex, cs, lat);
        chk("rd_byte_enable", rd, 32'hDE22_BE44);

        dual_a(1'b1, 4'hF, 32'h1000_0020, 32'hAAAA_AAAA, 1'b1, 4'hF, 32'h1000_0020, 32'h5555_5555, rd0, rd1);
        txn(0, 0, 1'b0, 4'hF, 32'h1000_0020, 32'h0, rd, ex, cs, lat);
        chk("rd_collide_full", rd, 32'h5555_5555);

        dual_a(1'b1, 4'b1110, 32'h1000_0030, 32'hAAAA_AAAA, 1'b1, 4'b0111, 32'h1000_0030, 32'h5555_5555, rd0, rd1);
        txn(0, 1, 1'b0, 4'hF, 32'h1000_0030, 32'h0, rd, ex, cs, lat);
        chk("rd_collide_partial", rd, 32'hAA55_5555);

        txn(0, 0, 1'b1, 4'hF, 32'h1000_0040, 32'hCAFE_F00D, rd, ex, cs, lat);
        dual_a(1'b0, 4'hF, 32'h1000_0040, 32'h0, 1'b1, 4'hF, 32'h1000_0040, 32'h1234_5678, rd0, rd1);
        chk("rd_vs_wr_old", rd0, 32'hCAFE_F00D);
        txn(0, 0, 1'b0, 4'hF, 32'h1000_0040, 32'h0, rd, ex, cs, lat);
        chk("rd_vs_wr_new", rd, 32'h1234_5678);

        txn(0, 0, 1'b0, 4'hF, 32'h2000_0000, 32'h0, rd, ex, cs, lat);
        chk("oor_excpt", ex, 1'b1);
        chk("oor_cause", cs, 2'd1);
        chk("oor_rdata", rd, 32'h0);

        txn(0, 1, 1'b0, 4'hF, 32'h1000_00FC, 32'h0, rd, ex, cs, lat);
        chk("top_word_ok", {ex, cs}, 3'b000);
        txn(0, 1, 1'b0, 4'hF, 32'h1000_00FD, 32'h0, rd, ex, cs, lat);
        chk("cross_top_cause", {ex, cs}, 3'b101);

        txn(0, 0, 1'b1, 4'hF, 32'h1000_0000, 32'h0102_0304, rd, ex, cs, lat);
        txn(0, 0, 1'b1, 4'hF, 32'h1000_0004, 32'h0506_0708, rd, ex, cs, lat);
        txn(0, 0, 1'b0, 4'hF, 32'h1000_0001, 32'h0, rd, ex, cs, lat);
`ifdef ARM_MEM_STRICT_ALIGN_EN
        chk("unaligned_cause", {ex, cs}, 3'b110);
        chk("unaligned_rdata", rd, 32'h0);
`else
        chk("unaligned_cause", {ex, cs}, 3'b000);
        chk("unaligned_rdata", rd, 32'h0203_0405);
`endif

        txn(0, 1, 1'b1, 4'hF, 32'h0000_0004, 32'h0BAD_F00D, rd, ex, cs, lat);
        chk("text_wr_ok", {ex, cs}, 3'b000);
        txn(0, 0, 1'b0, 4'hF, 32'h0000_0004, 32'h0, rd, ex, cs, lat);
        chk("text_rd", rd, 32'h0BAD_F00D);

        txn(1, 0, 1'b0, 4'hF, 32'h0000_0000, 32'h0, v0, ex, cs, lat);
        chk("b_latency", lat, 4);
        txn(1, 0, 1'b1, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF, rd, ex, cs, lat);
        chk("text_prot_cause", {ex, cs}, 3'b111);
        txn(1, 0, 1'b0, 4'hF, 32'h0000_0000, 32'h0, rd, ex, cs, lat);
        chk("text_unchanged", rd, v0);
        txn(1, 0, 1'b1, 4'hF, 32'h1000_0000, 32'hA5A5_A5A5, rd, ex, cs, lat);
        chk("b_data_wr_ok", {ex, cs}, 3'b000);

        // Wait states with a stalled response.
        @(posedge clk); #1;
        drv(1, 0, 1'b1, 1'b0, 4'hF, 32'h1000_0000, 32'h0);
        @(posedge clk); #1;
        drv(1, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        lat = 0;
        bad = 1'b0;
        while (!ib.resp_valid[0] && lat < 20) begin
            if (ib.req_ready[0]) bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        chk("ws3_latency", lat, 4);
        chk("ws3_ready_low_wait", bad, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", ib.resp_valid[0], 1'b1);
            chk("stall_rdata", ib.resp_rdata[31:0], 32'hA5A5_A5A5);
            chk("stall_ready_low", ib.req_ready[0], 1'b0);
            @(posedge clk); #1;
        end
        rresp(1, 0, 1'b1);
        @(posedge clk); #1;
        rresp(1, 0, 1'b0);
        chk("post_hs_valid", ib.resp_valid[0], 1'b0);
        chk("post_hs_ready", ib.req_ready[0], 1'b1);

        // Reset while a port-1 request sits in WAIT.
        @(posedge clk); #1;
        drv(1, 1, 1'b1, 1'b0, 4'hF, 32'h1000_0000, 32'h0);
        @(posedge clk); #1;
        drv(1, 1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ib.resp_valid, 2'b00);
        chk("mid_rst_ready", ib.req_ready, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 1'b0;
        ib.resp_ready = 2'b00;
        repeat (8) begin
            @(posedge clk); #1;
            if (ib.resp_valid != 2'b00) bad = 1'b1;
        end
        chk("no_resp_after_rst", bad, 1'b0);
        txn(1, 1, 1'b0, 4'hF, 32'h1000_0000, 32'h0, rd, ex, cs, lat);
        chk("b_retained", rd, 32'hA5A5_A5A5);
        txn(0, 0, 1'b0, 4'hF, 32'h1000_0010, 32'h0, rd, ex, cs, lat);
        chk("a_retained", rd, 32'hDE22_BE44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
